// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter: FSM state encoding,
// requester identifiers and a small grant helper.
// Optional feature macro: MEM_ARBITER_ROUND_ROBIN_EN (alternating tie-break).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_e;

    // Plain-vector state constants for the FSM register.
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_RESP = RESP;

    // The requester that is not the given one (round-robin tie-break).
    function automatic req_id_e other_id(input req_id_e id);
        req_id_e res;
        if (id == REQ_IF) begin
            res = REQ_LS;
        end else begin
            res = REQ_IF;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and shared-memory signals around mem_arbiter.
// slave: arbiter side; master: requesters plus memory side.
interface mem_arbiter_if;

    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic [31:0] o_if_rdata;
    logic        o_if_valid;
    logic        o_if_stall;

    logic        i_ls_req;
    logic        i_ls_we;
    logic [31:0] i_ls_addr;
    logic [31:0] i_ls_wdata;
    logic [31:0] o_ls_rdata;
    logic        o_ls_valid;
    logic        o_ls_stall;

    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_rdata, o_if_valid, o_if_stall,
        input  i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata,
        output o_ls_rdata, o_ls_valid, o_ls_stall,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_ack, i_mem_rdata
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_rdata, o_if_valid, o_if_stall,
        output i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata,
        input  o_ls_rdata, o_ls_valid, o_ls_stall,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_ack, i_mem_rdata
    );

endinterface

// File: rtl/mem_arb_picker.sv
// Grant selection between fetch and load/store requesters.
// With MEM_ARBITER_ROUND_ROBIN_EN a tie goes to the requester not granted
// last; otherwise load/store always wins a tie and last_grant is ignored.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic    if_req,
    input  logic    ls_req,
    input  req_id_e last_grant,
    output logic    grant_valid,
    output req_id_e grant_id
);

`ifndef MEM_ARBITER_ROUND_ROBIN_EN
    logic unused_s;
    assign unused_s = last_grant;
`endif

    // Combinational winner selection from the current requests.
    always_comb begin
        grant_valid = if_req | ls_req;
        grant_id    = REQ_IF;
        if (if_req && ls_req) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            grant_id = other_id(last_grant);
`else
            grant_id = REQ_LS;
`endif
        end else if (ls_req) begin
            grant_id = REQ_LS;
        end else begin
            grant_id = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch, load/store) onto one shared memory port.
// IDLE -> BUSY (wait for ack) -> RESP (one-cycle valid) -> IDLE.
// A requester that drops its request while BUSY is treated as flushed:
// the memory access completes but no valid pulse or rdata update follows.
// Optional feature macro: MEM_ARBITER_ROUND_ROBIN_EN (alternating tie-break).
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    logic [1:0]  state_r;
    req_id_e     owner_r;
    logic        flushed_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [31:0] if_rdata_r;
    logic [31:0] ls_rdata_r;
    logic        if_valid_r;
    logic        ls_valid_r;

    logic        grant_valid_s;
    req_id_e     grant_id_s;
    req_id_e     last_grant_s;
    logic        winner_req_s;
    logic        kill_s;

    mem_arb_picker u_picker (
        .if_req      (bus.i_if_req),
        .ls_req      (bus.i_ls_req),
        .last_grant  (last_grant_s),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    req_id_e last_grant_r;

    // Remember which requester was granted most recently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= REQ_IF;
        end else if ((state_r == ST_IDLE) && grant_valid_s) begin
            last_grant_r <= grant_id_s;
        end
    end

    assign last_grant_s = last_grant_r;
`else
    assign last_grant_s = REQ_IF;
`endif

    // Current request level of the requester owning the transaction.
    always_comb begin
        if (owner_r == REQ_LS) begin
            winner_req_s = bus.i_ls_req;
        end else begin
            winner_req_s = bus.i_if_req;
        end
        kill_s = flushed_r | ~winner_req_s;
    end

    // Arbitration FSM and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            owner_r     <= REQ_IF;
            flushed_r   <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            if_rdata_r  <= 32'h0000_0000;
            ls_rdata_r  <= 32'h0000_0000;
            if_valid_r  <= 1'b0;
            ls_valid_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if_valid_r <= 1'b0;
                    ls_valid_r <= 1'b0;
                    if (grant_valid_s) begin
                        owner_r   <= grant_id_s;
                        flushed_r <= 1'b0;
                        mem_req_r <= 1'b1;
                        state_r   <= ST_BUSY;
                        if (grant_id_s == REQ_LS) begin
                            mem_we_r    <= bus.i_ls_we;
                            mem_addr_r  <= bus.i_ls_addr;
                            mem_wdata_r <= bus.i_ls_wdata;
                        end else begin
                            mem_we_r    <= 1'b0;
                            mem_addr_r  <= bus.i_if_addr;
                            mem_wdata_r <= 32'h0000_0000;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!winner_req_s) begin
                        flushed_r <= 1'b1;
                    end
                    if (bus.i_mem_ack) begin
                        mem_req_r <= 1'b0;
                        state_r   <= ST_RESP;
                        if (!kill_s) begin
                            if (owner_r == REQ_LS) begin
                                ls_valid_r <= 1'b1;
                                if (!mem_we_r) begin
                                    ls_rdata_r <= bus.i_mem_rdata;
                                end
                            end else begin
                                if_valid_r <= 1'b1;
                                if_rdata_r <= bus.i_mem_rdata;
                            end
                        end
                    end
                end
                ST_RESP: begin
                    if_valid_r <= 1'b0;
                    ls_valid_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    mem_req_r  <= 1'b0;
                    if_valid_r <= 1'b0;
                    ls_valid_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_mem_req   = mem_req_r;
    assign bus.o_mem_we    = mem_we_r;
    assign bus.o_mem_addr  = mem_addr_r;
    assign bus.o_mem_wdata = mem_wdata_r;
    assign bus.o_if_rdata  = if_rdata_r;
    assign bus.o_ls_rdata  = ls_rdata_r;
    assign bus.o_if_valid  = if_valid_r;
    assign bus.o_ls_valid  = ls_valid_r;
    assign bus.o_if_stall  = bus.i_if_req & ~if_valid_r;
    assign bus.o_ls_stall  = bus.i_ls_req & ~ls_valid_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single-requester transactions
// plus hand-written sequences for ties, spurious ack, reset mid-transaction
// and tie-break ordering (MEM_ARBITER_ROUND_ROBIN_EN aware).
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;

    typedef struct {
        logic        ls;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] mrdata;
        logic        flush;
        logic        exp_valid;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_ls_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bus.i_ls_req   = v.ls;
        bus.i_if_req   = !v.ls;
        bus.i_ls_we    = v.we;
        bus.i_ls_addr  = v.ls ? v.addr : 32'h0;
        bus.i_if_addr  = v.ls ? 32'h0 : v.addr;
        bus.i_ls_wdata = v.wdata;
        tick;
        chk($sformatf("v%0d_start_req", idx), {31'h0, bus.o_mem_req}, 32'h1);
        chk($sformatf("v%0d_start_we", idx), {31'h0, bus.o_mem_we}, {31'h0, v.we});
        chk($sformatf("v%0d_start_addr", idx), bus.o_mem_addr, v.addr);
        if (v.we) chk($sformatf("v%0d_start_wdata", idx), bus.o_mem_wdata, v.wdata);
        chk($sformatf("v%0d_start_stall", idx),
            {31'h0, (v.ls ? bus.o_ls_stall : bus.o_if_stall)}, 32'h1);
        if (v.flush) begin
            bus.i_ls_req = 1'b0;
            bus.i_if_req = 1'b0;
        end
        for (int c = 0; c < v.dly; c++) begin
            tick;
            chk($sformatf("v%0d_busy_req", idx), {31'h0, bus.o_mem_req}, 32'h1);
            chk($sformatf("v%0d_busy_addr", idx), bus.o_mem_addr, v.addr);
        end
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = v.mrdata;
        tick;
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = 32'h0;
        chk($sformatf("v%0d_resp_valid", idx),
            {31'h0, (v.ls ? bus.o_ls_valid : bus.o_if_valid)}, {31'h0, v.exp_valid});
        chk($sformatf("v%0d_resp_other_valid", idx),
            {31'h0, (v.ls ? bus.o_if_valid : bus.o_ls_valid)}, 32'h0);
        chk($sformatf("v%0d_if_rdata", idx), bus.o_if_rdata, v.exp_if_rdata);
        chk($sformatf("v%0d_ls_rdata", idx), bus.o_ls_rdata, v.exp_ls_rdata);
        chk($sformatf("v%0d_resp_memreq", idx), {31'h0, bus.o_mem_req}, 32'h0);
        chk($sformatf("v%0d_resp_stall", idx),
            {31'h0, (v.ls ? bus.o_ls_stall : bus.o_if_stall)}, 32'h0);
        bus.i_ls_req = 1'b0;
        bus.i_if_req = 1'b0;
        tick;
        chk($sformatf("v%0d_end_valids", idx),
            {30'h0, bus.o_if_valid, bus.o_ls_valid}, 32'h0);
        chk($sformatf("v%0d_end_memreq", idx), {31'h0, bus.o_mem_req}, 32'h0);
    endtask

    initial begin
        logic [31:0] rr_exp [4];
        logic        got;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 3, 32'h0050_0093, 1'b0, 1'b1, 32'h0050_0093, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 0, 32'h1234_5678, 1'b0, 1'b1, 32'h0050_0093, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0050_0093, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0, 2, 32'hAAAA_5555, 1'b1, 1'b0, 32'h0050_0093, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0, 1, 32'h1111_2222, 1'b1, 1'b0, 32'h0050_0093, 32'h1234_5678};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0048, 32'h0, 1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h1234_5678};

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        rr_exp = '{32'h0000_0500, 32'h0000_0600, 32'h0000_0500, 32'h0000_0600};
`else
        rr_exp = '{32'h0000_0500, 32'h0000_0500, 32'h0000_0500, 32'h0000_0500};
`endif

        rst             = 1'b1;
        bus.i_if_req    = 1'b0;
        bus.i_if_addr   = 32'h0;
        bus.i_ls_req    = 1'b0;
        bus.i_ls_we     = 1'b0;
        bus.i_ls_addr   = 32'h0;
        bus.i_ls_wdata  = 32'h0;
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = 32'h0;
        tick;
        tick;
        chk("rst_mem_req", {31'h0, bus.o_mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, bus.o_mem_we}, 32'h0);
        chk("rst_mem_addr", bus.o_mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.o_mem_wdata, 32'h0);
        chk("rst_valids", {30'h0, bus.o_if_valid, bus.o_ls_valid}, 32'h0);
        chk("rst_if_rdata", bus.o_if_rdata, 32'h0);
        chk("rst_ls_rdata", bus.o_ls_rdata, 32'h0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Tie: store wins first, fetch waits stalled and completes second.
        bus.i_ls_req   = 1'b1;
        bus.i_ls_we    = 1'b1;
        bus.i_ls_addr  = 32'h0000_0100;
        bus.i_ls_wdata = 32'hDEAD_BEEF;
        bus.i_if_req   = 1'b1;
        bus.i_if_addr  = 32'h0000_0080;
        tick;
        chk("tie_first_we", {31'h0, bus.o_mem_we}, 32'h1);
        chk("tie_first_addr", bus.o_mem_addr, 32'h0000_0100);
        chk("tie_first_wdata", bus.o_mem_wdata, 32'hDEAD_BEEF);
        chk("tie_if_stall_a", {31'h0, bus.o_if_stall}, 32'h1);
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = 32'h0BAD_C0DE;
        tick;
        bus.i_mem_ack = 1'b0;
        chk("tie_ls_valid", {31'h0, bus.o_ls_valid}, 32'h1);
        chk("tie_ls_rdata_kept", bus.o_ls_rdata, 32'h1234_5678);
        chk("tie_if_stall_b", {31'h0, bus.o_if_stall}, 32'h1);
        bus.i_ls_req = 1'b0;
        tick;
        chk("tie_if_stall_c", {31'h0, bus.o_if_stall}, 32'h1);
        tick;
        chk("tie_second_req", {31'h0, bus.o_mem_req}, 32'h1);
        chk("tie_second_addr", bus.o_mem_addr, 32'h0000_0080);
        chk("tie_second_we", {31'h0, bus.o_mem_we}, 32'h0);
        bus.i_mem_ack = 1'b1;
        tick;
        bus.i_mem_ack = 1'b0;
        chk("tie_if_valid", {31'h0, bus.o_if_valid}, 32'h1);
        chk("tie_if_rdata", bus.o_if_rdata, 32'h0BAD_C0DE);
        chk("tie_if_stall_d", {31'h0, bus.o_if_stall}, 32'h0);
        bus.i_if_req = 1'b0;
        tick;

        // Spurious ack while idle.
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = 32'h5555_5555;
        tick;
        chk("spur_valids_a", {30'h0, bus.o_if_valid, bus.o_ls_valid}, 32'h0);
        chk("spur_memreq", {31'h0, bus.o_mem_req}, 32'h0);
        tick;
        chk("spur_valids_b", {30'h0, bus.o_if_valid, bus.o_ls_valid}, 32'h0);
        chk("spur_if_rdata", bus.o_if_rdata, 32'h0BAD_C0DE);
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = 32'h0;

        // Still idle: a fetch starts at once; then reset hits mid-transaction.
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 32'h0000_00C0;
        tick;
        chk("post_spur_req", {31'h0, bus.o_mem_req}, 32'h1);
        chk("post_spur_addr", bus.o_mem_addr, 32'h0000_00C0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_busy_memreq", {31'h0, bus.o_mem_req}, 32'h0);
        chk("rst_busy_addr", bus.o_mem_addr, 32'h0);
        chk("rst_busy_if_rdata", bus.o_if_rdata, 32'h0);
        bus.i_if_req    = 1'b0;
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = 32'h7777_7777;
        tick;
        rst = 1'b0;
        tick;
        chk("rst_late_ack_valid", {30'h0, bus.o_if_valid, bus.o_ls_valid}, 32'h0);
        bus.i_mem_ack = 1'b0;
        tick;
        chk("rst_after_valid", {30'h0, bus.o_if_valid, bus.o_ls_valid}, 32'h0);
        chk("rst_after_memreq", {31'h0, bus.o_mem_req}, 32'h0);
        chk("rst_after_if_rdata", bus.o_if_rdata, 32'h0);

        // Both requesters held across four transactions.
        bus.i_ls_req  = 1'b1;
        bus.i_ls_we   = 1'b0;
        bus.i_ls_addr = 32'h0000_0500;
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 32'h0000_0600;
        for (int t = 0; t < 4; t++) begin
            got = 1'b0;
            for (int k = 0; k < 6; k++) begin
                tick;
                if (bus.o_mem_req) begin
                    got = 1'b1;
                    break;
                end
            end
            chk($sformatf("rr%0d_started", t), {31'h0, got}, 32'h1);
            chk($sformatf("rr%0d_grant_addr", t), bus.o_mem_addr, rr_exp[t]);
            bus.i_mem_ack   = 1'b1;
            bus.i_mem_rdata = 32'h0000_1000 + t;
            tick;
            bus.i_mem_ack = 1'b0;
        end
        bus.i_ls_req = 1'b0;
        bus.i_if_req = 1'b0;
        tick;
        tick;

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port i_if_req, input, 1: fetch requester wants a read.
REQ-004 SHALL have port i_if_addr, input, 32: fetch address.
REQ-005 SHALL have port o_if_rdata, output, 32: fetched word, registered.
REQ-006 SHALL have port o_if_valid, output, 1: one-cycle pulse; o_if_rdata valid.
REQ-007 SHALL have port o_if_stall, output, 1: fetch must hold.
REQ-008 SHALL have port i_ls_req, input, 1: load/store requester wants access.
REQ-009 SHALL have ports i_ls_we (input, 1), i_ls_addr (input, 32) and i_ls_wdata (input, 32): write enable, address, store data.
REQ-010 SHALL have ports o_ls_rdata (output, 32), o_ls_valid (output, 1) and o_ls_stall (output, 1): same meanings as the fetch port.
REQ-011 SHALL have ports o_mem_req (output, 1), o_mem_we (output, 1), o_mem_addr (output, 32), o_mem_wdata (output, 32): shared memory port, all registered.
REQ-012 SHALL have ports i_mem_ack (input, 1) and i_mem_rdata (input, 32): memory completion and read data, sampled on the ack cycle.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 IDLE: if any request, SHALL pick winner, latch addr/we/wdata (we=0 for fetch) into o_mem_*, set o_mem_req=1 and go BUSY next cycle; else stay.
REQ-015 Default arbitration SHALL be fixed priority, load/store over fetch.
REQ-016 BUSY: SHALL hold o_mem_req and o_mem_* stable until i_mem_ack=1; on ack SHALL clear o_mem_req, capture i_mem_rdata into winner rdata (reads only) and go RESP.
REQ-017 RESP: SHALL pulse winner valid for exactly one cycle and go IDLE; the new-request sample occurs in IDLE, so minimum transaction time is ack latency + 2 cycles.
REQ-018 o_x_stall SHALL equal i_x_req AND NOT o_x_valid (combinational).
REQ-019 Store completion SHALL pulse o_ls_valid and leave o_ls_rdata unchanged.
REQ-020 If winner deasserts req during BUSY (flush), SHALL finish the memory transaction but suppress valid and leave rdata unchanged.
REQ-021 i_mem_ack in IDLE or RESP SHALL be ignored.
REQ-022 Simultaneous requests in IDLE SHALL grant exactly one; the loser's stall stays high until it is served.

Reset
REQ-023 On rst, SHALL immediately go IDLE and clear o_mem_req, o_mem_we, o_if_valid and o_ls_valid; o_mem_addr, o_mem_wdata, o_if_rdata and o_ls_rdata SHALL reset to 0.
REQ-024 Reset mid-BUSY SHALL drop the transaction; no valid SHALL follow.

Configuration
REQ-025 Macro MEM_ARBITER_ROUND_ROBIN_EN defined: SHALL grant the requester not granted last when both request; last-grant bit resets to fetch, so load/store wins the first tie.
REQ-026 Macro undefined: SHALL use fixed load/store priority per REQ-015 and keep no last-grant state.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the FSM state enum and the requester-id enum (REQ_IF, REQ_LS).
REQ-028 Sub-module mem_arb_picker SHALL compute the grant from the two requests and the last-grant bit.

Verification
REQ-029 Fetch read 0x0000_0040, ack 3 cycles after o_mem_req rises with rdata 0x0050_0093 -> o_if_valid one cycle after ack, o_if_rdata=0x0050_0093, o_mem_we=0.
REQ-030 Both request in IDLE, ls store 0x100 <= 0xDEAD_BEEF -> o_mem_we=1, addr 0x100 first; o_if_stall high until the fetch completes second.
REQ-031 Fetch request dropped during BUSY, then ack -> no o_if_valid; o_if_rdata unchanged; FSM back in IDLE.
REQ-032 rst asserted in BUSY -> o_mem_req=0 immediately; later ack ignored; no valid pulse.
REQ-033 With MEM_ARBITER_ROUND_ROBIN_EN, both held requesting for 4 transactions -> grants LS, IF, LS, IF; without the macro -> LS each time.
REQ-034 Spurious i_mem_ack in IDLE -> no valid, no state change.
